// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start validation, LSB-first
// centre sampling, stop check, and a one-entry valid/ready output register.
module uart_rx #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int HALF  = CYCLE / 2;
  localparam logic [15:0] CYC_M1  = 16'(CYCLE - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

  if (CYCLE < 4 || CYCLE > 65535) begin : g_bad_cycle
    $error("uart_rx: CYCLE out of range 4..65535");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_s1, r_rx_s, r_rx_d;
  logic [15:0] r_cycle_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        w_sample, w_stop_ok, w_ferr, w_state_chg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b1;
      r_rx_s <= 1'b1;
      r_rx_d <= 1'b1;
    end else begin
      r_s1   <= rx_pin;
      r_rx_s <= r_s1;
      r_rx_d <= r_rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_rx_d && !r_rx_s) w_next = S_START;
      S_START: if (r_cycle_cnt == HALF_M1) w_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (r_cycle_cnt == CYC_M1 && r_bit_cnt == 3'd7) w_next = S_STOP;
      S_STOP:  if (r_cycle_cnt == CYC_M1) w_next = r_rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (r_rx_s) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_state_chg = (w_next != r_state);
    w_sample    = (r_state == S_DATA) && (r_cycle_cnt == CYC_M1);
    w_stop_ok   = (r_state == S_STOP) && (r_cycle_cnt == CYC_M1) && r_rx_s;
    w_ferr      = (r_state == S_STOP) && (r_cycle_cnt == CYC_M1) && !r_rx_s;
  end

  // Counters, shift register and output register; a handshake in the same
  // cycle as a delivery frees the slot for the new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle_cnt   <= 16'd0;
      r_bit_cnt     <= 3'd0;
      r_shift       <= 8'd0;
      rx_data       <= 8'd0;
      rx_data_valid <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      r_cycle_cnt <= (w_state_chg || w_sample) ? 16'd0 : r_cycle_cnt + 16'd1;
      if (w_sample) begin
        r_shift[r_bit_cnt] <= r_rx_s;
        r_bit_cnt          <= r_bit_cnt + 3'd1;
      end
      rx_frame_err <= w_ferr;
      rx_overrun   <= w_stop_ok && rx_data_valid && !rx_data_ready;
      if (w_stop_ok && (!rx_data_valid || rx_data_ready)) begin
        rx_data       <= r_shift;
        rx_data_valid <= 1'b1;
      end else if (rx_data_valid && rx_data_ready) begin
        rx_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at default 50 MHz / 115200 baud.
module tb_uart_rx;

  localparam int CYCLE = 434;
  localparam int HALF  = 217;

  localparam int K_BYTE = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pin = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready = 1'b1;
  logic       rx_frame_err;
  logic       rx_overrun;

  uart_rx #(.CLK_FRE(50), .BAUD_RATE(115200)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_pin       (rx_pin),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input int kind, input logic [7:0] data, input int at);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.at   = at;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_evt(input int kind, input logic [7:0] data);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL evt_unexpected: got kind=%0d data=%h at cycle %0d, expected none", kind, data, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || (kind == K_BYTE && e.data !== data) ||
          (e.at >= 0 && e.at != cyc)) begin
        n_bad++;
        $display("FAIL evt: got kind=%0d data=%h cycle=%0d, expected kind=%0d data=%h cycle=%0d",
                 kind, data, cyc, e.kind, e.data, e.at);
      end
    end
  endtask

  // Monitor: a byte event is a rising valid, or valid still high after a
  // handshake (a back-to-back delivery); each flag cycle is its own event.
  logic pv = 1'b0;
  logic pr = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (rx_data_valid && (!pv || pr)) check_evt(K_BYTE, rx_data);
      if (rx_frame_err) check_evt(K_FERR, 8'h00);
      if (rx_overrun)   check_evt(K_OVR, 8'h00);
      pv = rx_data_valid;
      pr = rx_data_ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    rx_pin = 1'b0;
    tick(CYCLE);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      tick(CYCLE);
    end
    rx_pin = stop;
    tick(CYCLE);
  endtask

  int t0;

  initial begin
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    chk("rst_data",  32'(rx_data), 32'h00);
    chk("rst_valid", 32'(rx_data_valid), 32'h0);
    chk("rst_ferr",  32'(rx_frame_err), 32'h0);
    chk("rst_ovr",   32'(rx_overrun), 32'h0);
    tick(10000);
    chk("idle_data",  32'(rx_data), 32'h00);
    chk("idle_valid", 32'(rx_data_valid), 32'h0);
    chk("idle_ferr",  32'(rx_frame_err), 32'h0);
    chk("idle_ovr",   32'(rx_overrun), 32'h0);

    // 0x55 with ready held high; valid at edge 4125 after the start edge
    t0 = cyc;
    push(K_BYTE, 8'h55, t0 + 1 + 4125);
    send_byte(8'h55, 1'b1);
    tick(CYCLE);

    // Back-to-back with consumer stalled: second byte overruns
    rx_data_ready = 1'b0;
    push(K_BYTE, 8'hA5, -1);
    push(K_OVR,  8'h00, -1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    tick(10);
    chk("ovr_valid_held", 32'(rx_data_valid), 32'h1);
    chk("ovr_data_kept",  32'(rx_data), 32'hA5);
    rx_data_ready = 1'b1;
    tick(1);
    rx_data_ready = 1'b0;
    chk("ovr_valid_clear", 32'(rx_data_valid), 32'h0);
    chk("ovr_data_stable", 32'(rx_data), 32'hA5);
    tick(5);
    rx_data_ready = 1'b1;

    // Short low pulse is a glitch
    rx_pin = 1'b0;
    tick(100);
    rx_pin = 1'b1;
    tick(1000);
    chk("glitch_valid", 32'(rx_data_valid), 32'h0);

    // Framing error, long break, then a good byte
    push(K_FERR, 8'h00, -1);
    send_byte(8'h81, 1'b0);
    tick(2000);
    rx_pin = 1'b1;
    tick(CYCLE);
    chk("break_valid", 32'(rx_data_valid), 32'h0);
    push(K_BYTE, 8'h12, -1);
    send_byte(8'h12, 1'b1);
    tick(CYCLE);

    // Reset during bit 3 of 0xFF abandons it silently
    rx_pin = 1'b0;
    tick(CYCLE);
    rx_pin = 1'b1;
    tick(3 * CYCLE + HALF);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(6 * CYCLE);
    chk("rstmid_valid", 32'(rx_data_valid), 32'h0);
    push(K_BYTE, 8'h7E, -1);
    send_byte(8'h7E, 1'b1);
    tick(CYCLE);

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events: got %0d outstanding, expected 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
